dthresh_colgen: RTL

- Upstream neighbour of the hysteresis stage in the Canny edge pipeline.
- Accepts a raster-order gradient-magnitude stream, one pixel per cycle.
- Classifies each pixel against a double threshold: 0 = none, 1 = weak, 2 = strong.
- Buffers two classified lines and emits one 3-row column per cycle, with an enable strobe, in exactly the form the hysteresis stage consumes.

---
 rtl/dthresh_colgen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dthresh_colgen.sv
// Purpose: double-threshold classifier feeding a 3-row column window to the hysteresis stage.
// Latency: one cycle from an accepted streaming pixel to its registered column on enable.
// Backpressure: none; the source cannot be stalled, and a missing pixel while streaming raises err.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-low reset (0 = reset)
//   pixel_in, in_valid raster-order gradient magnitude and its qualifier
//   low_th, high_th    weak/strong thresholds, captured on the first pixel of a frame
//   pixel_out0..2      codes of rows y-2, y-1, y at the current column (zero-extended)
//   enable             pixel_out0..2 carry a valid column this cycle
//   done               whole frame emitted; sticky until reset
//   err                input gap seen while streaming; sticky until reset
module dthresh_colgen #(
  parameter int IMG_WIDTH  = 960,
  parameter int IMG_HEIGHT = 720,
  parameter int MAG_BITS   = 8,
  parameter int BIT_LENGTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MAG_BITS-1:0]   pixel_in,
  input  logic                  in_valid,
  input  logic [MAG_BITS-1:0]   low_th,
  input  logic [MAG_BITS-1:0]   high_th,
  output logic [BIT_LENGTH-1:0] pixel_out0,
  output logic [BIT_LENGTH-1:0] pixel_out1,
  output logic [BIT_LENGTH-1:0] pixel_out2,
  output logic                  enable,
  output logic                  done,
  output logic                  err
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [MAG_BITS-1:0] low_q, high_q, low_eff, high_eff;
  logic [1:0]          line_a [IMG_WIDTH];  // row y-2
  logic [1:0]          line_b [IMG_WIDTH];  // row y-1
  logic [1:0]          code, rd_a, rd_b;
  logic                col_last;
  logic                accept, emit, gap, latch_th, clr_out, set_done;

  assign col_last = (col == COL_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid) state_nxt = S_FILL;
      S_FILL:   if (in_valid && col_last && row == ROW_ONE) state_nxt = S_STREAM;
      S_STREAM: if (in_valid && col_last && row == ROW_LAST) state_nxt = S_DONE;
      default:  state_nxt = S_DONE;
    endcase
  end

  // Per-state control decode.
  always_comb begin
    accept   = 1'b0;
    emit     = 1'b0;
    gap      = 1'b0;
    latch_th = 1'b0;
    clr_out  = 1'b0;
    set_done = 1'b0;
    case (state)
      S_IDLE: begin
        accept   = in_valid;
        latch_th = in_valid;
      end
      S_FILL:   accept = in_valid;
      S_STREAM: begin
        accept = in_valid;
        emit   = in_valid;
        gap    = !in_valid;
      end
      default: begin
        clr_out  = 1'b1;
        set_done = 1'b1;
      end
    endcase
  end

  // The first pixel of a frame is classified with the live thresholds, which
  // are captured on that same edge; every later pixel uses the captured pair.
  assign low_eff  = latch_th ? low_th  : low_q;
  assign high_eff = latch_th ? high_th : high_q;

  // Strong test first so low_th > high_th simply yields no weak codes.
  always_comb begin
    code = 2'd0;
    if (pixel_in >= high_eff)     code = 2'd2;
    else if (pixel_in >= low_eff) code = 2'd1;
  end

  assign rd_a = line_a[col];
  assign rd_b = line_b[col];

  // Line buffers: not reset, rows 0 and 1 are always written before use.
  // Reads above see the old contents, so the shift below is read-before-write.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      line_a[col] <= rd_b;
      line_b[col] <= code;
    end
  end

  // Counters, thresholds and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      low_q      <= '0;
      high_q     <= '0;
      pixel_out0 <= '0;
      pixel_out1 <= '0;
      pixel_out2 <= '0;
      enable     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (latch_th) begin
        low_q  <= low_th;
        high_q <= high_th;
      end
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row + ROW_ONE;
        end else begin
          col <= col + COL_W'(1);
        end
      end
      enable <= emit;
      if (emit) begin
        pixel_out0 <= BIT_LENGTH'(rd_a);
        pixel_out1 <= BIT_LENGTH'(rd_b);
        pixel_out2 <= BIT_LENGTH'(code);
      end else if (clr_out) begin
        pixel_out0 <= '0;
        pixel_out1 <= '0;
        pixel_out2 <= '0;
      end
      if (gap)      err  <= 1'b1;
      if (set_done) done <= 1'b1;
    end
  end

endmodule
